// File: rtl/mic_pkg.sv
// Shared constants and types for the three-mic I2S capture controller.
package mic_pkg;

    localparam int unsigned NUM_MICS   = 3;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned FRAME_W    = NUM_MICS * SAMPLE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

    // Left-slot data bits after the one-bit I2S delay: indices 1..SAMPLE_W.
    function automatic logic in_capture_window(input logic [BIT_W-1:0] idx);
        return (idx >= BIT_W'(1)) && (idx <= BIT_W'(SAMPLE_W));
    endfunction

endpackage

// File: rtl/mic_lane_deser.sv
// One mic lane: shifts the MSB-first left-slot sample in on each BCLK rising sample.
module mic_lane_deser
    import mic_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                clear,
    input  logic                sample_stb,
    input  logic [BIT_W-1:0]    bit_idx,
    input  logic                serial_bit,
    output logic [SAMPLE_W-1:0] word
);

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            word <= '0;
        end else if (sample_stb && in_capture_window(bit_idx)) begin
            word <= {word[SAMPLE_W-2:0], serial_bit};
        end
    end

endmodule

// File: rtl/mic_array_capture_ctrl.sv
// I2S master for three left-slot mics: clock generation, warm-up discard,
// frame assembly and a single-entry valid/ready output with sticky overflow.
module mic_array_capture_ctrl
    import mic_pkg::*;
#(
    parameter int unsigned BCLK_HALF_DIV = 16,
    parameter int unsigned WARMUP_FRAMES = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                enable_in,
    input  logic [NUM_MICS-1:0] mic_data_in,
    output logic                i2s_clk_out,
    output logic                lrcl_clk_out,
    output logic [FRAME_W-1:0]  sample_out,
    output logic                frame_valid_out,
    input  logic                frame_ready_in,
    output logic                overflow_out,
    input  logic                clear_ovf_in
);

    localparam int unsigned DIV_W  = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam int unsigned WARM_W = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST      = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_TARGET   = WARM_W'(WARMUP_FRAMES);
    localparam logic [BIT_W-1:0]  LAST_DATA_BIT = BIT_W'(SAMPLE_W);

    cap_state_e         state;
    cap_state_e         state_next;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WARM_W-1:0]  warm_cnt;
    logic               frame_done;
    logic [FRAME_W-1:0] lanes_c;

    logic run_c;
    logic div_wrap_c;
    logic rise_stb_c;
    logic slot_end_c;
    logic drop_c;

    assign run_c      = (state != ST_IDLE) && enable_in;
    assign div_wrap_c = run_c && (div_cnt == DIV_LAST);
    assign rise_stb_c = div_wrap_c && !i2s_clk_out;
    assign slot_end_c = rise_stb_c && (bit_cnt == LAST_DATA_BIT);
    assign drop_c     = frame_done && frame_valid_out && !frame_ready_in;

    assign lrcl_clk_out = bit_cnt[BIT_W-1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (enable_in) state_next = ST_WARMUP;
            ST_WARMUP:  begin
                if (!enable_in) begin
                    state_next = ST_IDLE;
                end else if (warm_cnt >= WARM_TARGET) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: if (!enable_in) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Bit clock divider and frame bit position; held at zero whenever not running.
    always_ff @(posedge clk_in) begin
        if (rst_in || !run_c) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            i2s_clk_out <= 1'b0;
        end else if (div_wrap_c) begin
            div_cnt     <= '0;
            i2s_clk_out <= !i2s_clk_out;
            if (i2s_clk_out) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (state == ST_IDLE)) begin
            warm_cnt <= '0;
        end else if (slot_end_c && (state == ST_WARMUP) && (warm_cnt < WARM_TARGET)) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Lanes are complete one cycle after the last data bit is sampled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= slot_end_c && (state == ST_CAPTURE);
        end
    end

    for (genvar k = 0; k < NUM_MICS; k++) begin : g_lane
        mic_lane_deser u_lane (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .clear      (!run_c),
            .sample_stb (rise_stb_c),
            .bit_idx    (bit_cnt),
            .serial_bit (mic_data_in[k]),
            .word       (lanes_c[k*SAMPLE_W +: SAMPLE_W])
        );
    end

    // Single output slot: a frame arriving while the slot is full and not being
    // consumed is dropped and flagged.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sample_out      <= '0;
            frame_valid_out <= 1'b0;
            overflow_out    <= 1'b0;
        end else begin
            if (frame_done && (!frame_valid_out || frame_ready_in)) begin
                sample_out      <= lanes_c;
                frame_valid_out <= 1'b1;
            end else if (frame_valid_out && frame_ready_in) begin
                frame_valid_out <= 1'b0;
            end
            if (drop_c) begin
                overflow_out <= 1'b1;
            end else if (clear_ovf_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mic_array_capture_ctrl.sv
// Bench for mic_array_capture_ctrl: time-based reference model plus directed scenarios.
module tb_mic_array_capture_ctrl;

    localparam int HALF      = 16;
    localparam int WARM      = 2;
    localparam int FRAME_CYC = 64 * 2 * HALF;
    localparam int DONE_OFS  = HALF + 2 * HALF * 16;
    localparam int BIT8_OFS  = 8 * 2 * HALF + HALF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  mic_data = 3'b000;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        bclk;
    logic        lrcl;
    logic [47:0] sample;
    logic        valid;
    logic        ovf;

    always #5 clk = ~clk;

    mic_array_capture_ctrl #(
        .BCLK_HALF_DIV (HALF),
        .WARMUP_FRAMES (WARM)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .enable_in       (en),
        .mic_data_in     (mic_data),
        .i2s_clk_out     (bclk),
        .lrcl_clk_out    (lrcl),
        .sample_out      (sample),
        .frame_valid_out (valid),
        .frame_ready_in  (rdy),
        .overflow_out    (ovf),
        .clear_ovf_in    (clr)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Mic k word for frame f; frame WARM (the first kept frame) carries the reference values.
    function automatic logic [15:0] frame_word(input int k, input int f);
        logic [15:0] base;
        case (k)
            0:       base = 16'hA5C3;
            1:       base = 16'h8000;
            default: base = 16'h7FFF;
        endcase
        if (f == WARM) return base;
        return base ^ 16'((f * 4951 + k * 257) & 16'hFFFF);
    endfunction

    function automatic logic [47:0] frame_vec(input int f);
        return {frame_word(2, f), frame_word(1, f), frame_word(0, f)};
    endfunction

    // Serial bit for mic k at absolute bit number g since capture start.
    function automatic logic mic_bit(input int k, input int g);
        int j;
        int f;
        logic [15:0] w;
        j = g % 64;
        f = g / 64;
        if (j >= 1 && j <= 16) begin
            w = frame_word(k, f);
            return w[16-j];
        end
        if (j <= 31) return 1'b1;
        return (j % 2) == 1;
    endfunction

    // Reference model: n counts clk edges since the run started.
    bit          m_active = 1'b0;
    bit          m_pend = 1'b0;
    int          m_pend_f = 0;
    int          m_n = 0;
    logic        m_bclk = 1'b0;
    logic        m_lrcl = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic [47:0] m_sample = '0;

    always @(posedge clk) begin
        bit load;
        bit drop;
        int lf;
        if (rst) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_n      = 0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_sample = '0;
        end else begin
            load = m_pend;
            lf   = m_pend_f;
            if (!en) begin
                m_active = 1'b0;
                m_n      = 0;
                m_pend   = 1'b0;
            end else begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_n      = 0;
                end else begin
                    m_n++;
                end
                m_pend   = (m_n % FRAME_CYC == DONE_OFS) && (m_n / FRAME_CYC >= WARM);
                m_pend_f = m_n / FRAME_CYC;
            end
            drop = 1'b0;
            if (load) begin
                if (!m_valid || rdy) begin
                    m_sample = frame_vec(lf);
                    m_valid  = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        m_bclk = m_active && ((m_n / HALF) % 2 == 1);
        m_lrcl = m_active && ((m_n / (64 * HALF)) % 2 == 1);
    end

    // Mics: present the bit that the next BCLK rising sample will take.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            mic_data[k] = m_active ? mic_bit(k, (m_n + 1 + 15) / (2 * HALF)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("i2s_clk_out", 48'(bclk), 48'(m_bclk));
            check("lrcl_clk_out", 48'(lrcl), 48'(m_lrcl));
            check("frame_valid_out", 48'(valid), 48'(m_valid));
            check("sample_out", sample, m_sample);
            check("overflow_out", 48'(ovf), 48'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int k = 0;
        while (valid !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        check(name, 48'(valid), 48'd1);
    endtask

    task automatic wait_n(input string name, input int target, input int bound);
        int k = 0;
        while (m_n != target && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (m_n != target) begin
            failures++;
            $display("FAIL %s: timeline at %0d expected %0d", name, m_n, target);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bclk"}, 48'(bclk), 48'd0);
        check({tag, "_lrcl"}, 48'(lrcl), 48'd0);
        check({tag, "_valid"}, 48'(valid), 48'd0);
        check({tag, "_ovf"}, 48'(ovf), 48'd0);
        check({tag, "_sample"}, sample, 48'd0);
    endtask

    initial begin
        int k;
        tick();
        chk_en = 1'b1;
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Clock timing after enable.
        en = 1'b1;
        tick();
        k = 0;
        while (bclk !== 1'b1 && k < 100) begin tick(); k++; end
        check("first_bclk_rise", 48'(k), 48'd16);
        k = 0;
        while (bclk === 1'b1 && k < 200) begin tick(); k++; end
        while (bclk !== 1'b1 && k < 200) begin tick(); k++; end
        check("bclk_period", 48'(k), 48'd32);
        k = 0;
        while (lrcl !== 1'b1 && k < 3000) begin tick(); k++; end
        check("lrcl_rise_seen", 48'(lrcl), 48'd1);
        k = 0;
        while (lrcl === 1'b1 && k < 3000) begin tick(); k++; end
        check("lrcl_high_len", 48'(k), 48'd1024);

        // First kept frame is the third frame.
        wait_valid("first_valid", 5000);
        check("first_valid_cycle", 48'(m_n), 48'd4625);
        check("first_sample", sample, 48'h7FFF_8000_A5C3);

        // Backpressure across one further frame: held, next dropped, sticky overflow.
        repeat (4000) tick();
        check("held_sample", sample, 48'h7FFF_8000_A5C3);
        check("held_valid", 48'(valid), 48'd1);
        check("ovf_set", 48'(ovf), 48'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_cleared", 48'(ovf), 48'd0);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("consumed", 48'(valid), 48'd0);

        // Ready exactly in the load cycle of frame 5.
        wait_n("to_load5", 5 * FRAME_CYC + DONE_OFS, 3000);
        check("frame4_pending", 48'(valid), 48'd1);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("coinc_valid", 48'(valid), 48'd1);
        check("coinc_ovf", 48'(ovf), 48'd0);
        check("coinc_sample", sample, frame_vec(5));

        // Stop mid-frame with a frame pending.
        wait_n("to_stop", 6 * FRAME_CYC + BIT8_OFS, 3000);
        check("pre_stop_bclk", 48'(bclk), 48'd1);
        en = 1'b0;
        tick();
        check("stop_bclk", 48'(bclk), 48'd0);
        check("stop_lrcl", 48'(lrcl), 48'd0);
        check("stop_valid", 48'(valid), 48'd1);
        repeat (3000) tick();
        check("stop_no_new", sample, frame_vec(5));
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("stop_handshake", 48'(valid), 48'd0);

        // Restart, then reset mid-frame with a frame pending.
        en = 1'b1;
        tick();
        wait_valid("restart_valid", 5000);
        check("restart_cycle", 48'(m_n), 48'd4625);
        check("restart_sample", sample, 48'h7FFF_8000_A5C3);
        wait_n("to_reset", 3 * FRAME_CYC + BIT8_OFS, 3000);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        wait_valid("post_rst_valid", 5000);
        check("post_rst_cycle", 48'(m_n), 48'd4625);
        check("post_rst_sample", sample, 48'h7FFF_8000_A5C3);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mic_array_capture_ctrl.md
MIC_ARRAY_CAPTURE_CTRL -- requirements
Module: mic_array_capture_ctrl

Interface
REQ-001 Parameter BCLK_HALF_DIV, default 16: clk_in cycles per i2s_clk_out half-period (98.304 MHz / 32 = 3.072 MHz).
REQ-002 Parameter WARMUP_FRAMES, default 2: whole frames discarded after enable, for mic startup.
REQ-003 Port clk_in, input, 1: sole clock (audio clock); all logic on its rising edge.
REQ-004 Port rst_in, input, 1: synchronous, active-high reset.
REQ-005 Port enable_in, input, 1: level; 1 = run capture, 0 = stop.
REQ-006 Port mic_data_in, input, 3: serial data, bit k from mic k; all mics share the clocks and have SEL grounded (left slot).
REQ-007 Port i2s_clk_out, output, 1: shared I2S bit clock to all mics.
REQ-008 Port lrcl_clk_out, output, 1: shared word select, 0 = left slot.
REQ-009 Port sample_out, output, 48: signed 16-bit samples, mic k at bits [16k+15:16k].
REQ-010 Port frame_valid_out, output, 1: sample_out holds an unconsumed frame.
REQ-011 Port frame_ready_in, input, 1: consumer accepts the frame when it is high together with frame_valid_out.
REQ-012 Port overflow_out, output, 1: sticky flag; a frame was dropped.
REQ-013 Port clear_ovf_in, input, 1: clears overflow_out.

Function
REQ-014 The FSM SHALL have states IDLE, WARMUP and CAPTURE.
REQ-015 IDLE -> WARMUP when enable_in=1. WARMUP -> CAPTURE after WARMUP_FRAMES complete frames. Any state -> IDLE in the cycle after enable_in=0.
REQ-016 In IDLE, i2s_clk_out=0, lrcl_clk_out=0, the divider and 6-bit bit counter are 0, and the lane shift registers are cleared.
REQ-017 Divider: counts 0..BCLK_HALF_DIV-1; on wrap it toggles i2s_clk_out.
REQ-018 Bit counter: increments on each i2s_clk_out falling toggle and wraps 63 -> 0; lrcl_clk_out = bit_cnt[5], so it changes with falling BCLK.
REQ-019 Sampling: mic_data_in is sampled in the clk_in cycle where i2s_clk_out toggles 0 -> 1; sampled bit index = bit_cnt.
REQ-020 Capture: left-slot bits 1..16 (MSB first, 1-bit I2S delay) are shifted into each lane. Bit 0, bits 17..31 and the right slot (bits 32..63) are ignored.
REQ-021 Frame completion: the rising-edge sample of bit 16 while in CAPTURE. One cycle later, all three lanes load sample_out together.
REQ-022 In WARMUP, completed frames are counted, never output, and never set the overflow flag.
REQ-023 Handshake: frame_valid_out rises with the sample_out load and stays high until the cycle after a cycle with frame_ready_in=1. sample_out is stable while valid.
REQ-024 Load with frame_valid_out=0: frame is loaded.
REQ-025 Load with frame_valid_out=1 and frame_ready_in=1 in the same cycle: the old frame is consumed, the new frame is loaded, valid stays 1, no overflow.
REQ-026 Load with frame_valid_out=1 and frame_ready_in=0: the new frame is dropped, the old frame is retained, overflow_out=1.
REQ-027 clear_ovf_in clears overflow_out. A drop in the same cycle wins, so overflow_out stays 1.
REQ-028 enable_in falling: a pending valid frame stays valid until handshaked. A partial frame is discarded.
REQ-029 Frame rate: one frame per 64 x 2 x BCLK_HALF_DIV clk_in cycles (2048 at default = 48 kHz).

Reset
REQ-030 While rst_in=1, state=IDLE and all counters = 0.
REQ-031 While rst_in=1, all outputs = 0: sample_out=0, frame_valid_out=0, overflow_out=0, i2s_clk_out=0, lrcl_clk_out=0.
REQ-032 Reset mid-frame or mid-handshake abandons all data. Capture restarts from WARMUP only after rst_in=0 and enable_in=1.

Structure
REQ-033 Shared package mic_pkg SHALL hold: NUM_MICS=3, SAMPLE_W=16, SLOT_BITS=32, FRAME_BITS=64, and the capture state enum typedef.
REQ-034 One sub-module, mic_lane_deser, instantiated NUM_MICS times. Inputs: clk_in, rst_in, clear, sample strobe, bit index, serial bit. Output: 16-bit word.
REQ-035 Scheduling (divider, bit counter, FSM, handshake) SHALL remain in the top module.

Verification
REQ-036 Clocks: reset, then enable=1 -> first i2s_clk_out rise at cycle 16 after enable, period 32 cycles; lrcl_clk_out period 2048, high for 1024.
REQ-037 Data: WARMUP_FRAMES=2; mics drive 0xA5C3, 0x8000, 0x7FFF at bits 1..16 with bits 17..31 = 1. Response: the first valid frame is the third frame, sample_out = {0x7FFF, 0x8000, 0xA5C3}.
REQ-038 Backpressure: frame_ready_in=0 for 2 frame periods. Response: first frame held unchanged, second dropped, overflow_out=1; clear_ovf_in pulse -> overflow_out=0.
REQ-039 Coincidence: frame_ready_in=1 exactly in the load cycle. Response: new frame loaded, frame_valid_out continuously 1, overflow_out=0.
REQ-040 Stop/reset: enable_in=0 at bit_cnt=8 -> clocks 0 within 1 cycle, no new valid, pending frame still handshakes. Repeating with rst_in=1 instead -> all outputs 0 next cycle.
